// File: rtl/riscv_pkg.sv
// Core-wide architectural constants shared by the data-path blocks.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two requesters, the data memory and dmem_arbiter.
// slave = arbiter view; master = requester/memory side view.
interface dmem_arbiter_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic            core_req_i,    dbg_req_i;
  logic            core_we_i,     dbg_we_i;
  logic [XLEN-1:0] core_addr_i,   dbg_addr_i;
  logic [XLEN-1:0] core_wdata_i,  dbg_wdata_i;
  logic [3:0]      core_be_i,     dbg_be_i;
  logic            core_gnt_o,    dbg_gnt_o;
  logic            core_rvalid_o, dbg_rvalid_o;
  logic [XLEN-1:0] core_rdata_o,  dbg_rdata_o;
  logic            core_err_o,    dbg_err_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [3:0]      mem_be_o;
  logic [XLEN-1:0] mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i,
    input  mem_rdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i,
    output mem_rdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core LSU / debug port arbiter for one data-memory port: 0-cycle grant, 1-cycle response, no response stall.
// Fixed core priority with debug starvation guard; define DMEM_ARB_RR_EN for round-robin on conflict.
module dmem_arbiter #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] MEM_BASE  = 32'h8000_0000,
  parameter logic [XLEN-1:0] MEM_BYTES = 32'h0001_0000,
  parameter int              MAX_WAIT  = 8
) (
  input logic            clk_i,
  input logic            rstn_i,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_DBG  = 2'd2;

  logic [XLEN-1:0] core_off, dbg_off;
  logic            core_in_win, dbg_in_win;
  logic            dbg_wins;
  logic            core_gnt, dbg_gnt;
  logic [1:0]      owner_q, owner_d;
  logic            err_q, err_d;
  logic            rd_q, rd_d;
  logic [XLEN-1:0] resp_data;

  // Modulo subtraction folds the below-base case into a single unsigned compare.
  assign core_off    = bus.core_addr_i - MEM_BASE;
  assign dbg_off     = bus.dbg_addr_i - MEM_BASE;
  assign core_in_win = core_off < MEM_BYTES;
  assign dbg_in_win  = dbg_off < MEM_BYTES;

`ifdef DMEM_ARB_RR_EN
  localparam logic WIN_CORE = 1'b0;
  localparam logic WIN_DBG  = 1'b1;

  logic last_winner_q, last_winner_d;

  assign dbg_wins = bus.dbg_req_i & (~bus.core_req_i | (last_winner_q == WIN_CORE));

  always_comb begin
    last_winner_d = last_winner_q;
    if (core_gnt)     last_winner_d = WIN_CORE;
    else if (dbg_gnt) last_winner_d = WIN_DBG;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_winner_q <= WIN_CORE;
    else         last_winner_q <= last_winner_d;
  end
`else
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign dbg_wins = bus.dbg_req_i & (~bus.core_req_i | (wait_cnt_q == WAIT_W'(MAX_WAIT)));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dbg_gnt)
      wait_cnt_d = '0;
    else if (bus.dbg_req_i && (wait_cnt_q != WAIT_W'(MAX_WAIT)))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) wait_cnt_q <= '0;
    else         wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign core_gnt       = bus.core_req_i & ~dbg_wins;
  assign dbg_gnt        = dbg_wins;
  assign bus.core_gnt_o = core_gnt;
  assign bus.dbg_gnt_o  = dbg_gnt;

  // Memory bus stays all-zero unless an in-window access is granted.
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    if (core_gnt && core_in_win) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = bus.core_we_i;
      bus.mem_addr_o  = core_off;
      bus.mem_wdata_o = bus.core_wdata_i;
      bus.mem_be_o    = bus.core_be_i;
    end else if (dbg_gnt && dbg_in_win) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = bus.dbg_we_i;
      bus.mem_addr_o  = dbg_off;
      bus.mem_wdata_o = bus.dbg_wdata_i;
      bus.mem_be_o    = bus.dbg_be_i;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    if (core_gnt) begin
      owner_d = OWN_CORE;
      err_d   = ~core_in_win;
      rd_d    = ~bus.core_we_i;
    end else if (dbg_gnt) begin
      owner_d = OWN_DBG;
      err_d   = ~dbg_in_win;
      rd_d    = ~bus.dbg_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign resp_data = (rd_q && !err_q) ? bus.mem_rdata_i : '0;

  assign bus.core_rvalid_o = (owner_q == OWN_CORE);
  assign bus.core_err_o    = bus.core_rvalid_o & err_q;
  assign bus.core_rdata_o  = bus.core_rvalid_o ? resp_data : '0;
  assign bus.dbg_rvalid_o  = (owner_q == OWN_DBG);
  assign bus.dbg_err_o     = bus.dbg_rvalid_o & err_q;
  assign bus.dbg_rdata_o   = bus.dbg_rvalid_o ? resp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-requester traffic plus
// hand sequences for arbitration and reset-with-pending-response.
module tb_dmem_arbiter;

  logic clk_i;
  logic rstn_i;
  int   checks;
  int   failures;

  dmem_arbiter_if #(.XLEN(32)) bus ();

  dmem_arbiter #(
    .XLEN      (32),
    .MEM_BASE  (32'h8000_0000),
    .MEM_BYTES (32'h0001_0000),
    .MAX_WAIT  (8)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [31:0] mrd;
    logic [1:0]  gnt;
    logic [69:0] mbus;
    logic [33:0] cresp;
    logic [33:0] dresp;
  } vec_t;

  function automatic logic [69:0] mb(logic req, logic we, logic [31:0] addr,
                                     logic [31:0] wd, logic [3:0] be);
    return {req, we, addr, wd, be};
  endfunction

  function automatic logic [33:0] rs(logic vld, logic err, logic [31:0] d);
    return {vld, err, d};
  endfunction

  function automatic vec_t v(logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                             logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd,
                             logic [31:0] mrd, logic [1:0] gnt, logic [69:0] mbus,
                             logic [33:0] cresp, logic [33:0] dresp);
    vec_t r;
    r.creq = creq; r.cwe = cwe; r.caddr = caddr; r.cwd = cwd;
    r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dwd = dwd;
    r.mrd = mrd; r.gnt = gnt; r.mbus = mbus; r.cresp = cresp; r.dresp = dresp;
    return r;
  endfunction

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [69:0] mem_bus();
    return {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o};
  endfunction

  function automatic logic [33:0] core_resp();
    return {bus.core_rvalid_o, bus.core_err_o, bus.core_rdata_o};
  endfunction

  function automatic logic [33:0] dbg_resp();
    return {bus.dbg_rvalid_o, bus.dbg_err_o, bus.dbg_rdata_o};
  endfunction

  task automatic drive(logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                       logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd,
                       logic [31:0] mrd);
    bus.core_req_i   = creq;
    bus.core_we_i    = cwe;
    bus.core_addr_i  = caddr;
    bus.core_wdata_i = cwd;
    bus.dbg_req_i    = dreq;
    bus.dbg_we_i     = dwe;
    bus.dbg_addr_i   = daddr;
    bus.dbg_wdata_i  = dwd;
    bus.mem_rdata_i  = mrd;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  // Both requesters issue reads; check the grant pair {core, dbg}.
  task automatic arb_step(logic cr, logic dr, logic [1:0] exp, string name);
    @(negedge clk_i);
    drive(cr, 0, 32'h8000_0000, 0, dr, 0, 32'h8000_0100, 0, 32'h0BAD_F00D);
    #2;
    chk(name, {bus.core_gnt_o, bus.dbg_gnt_o}, exp);
  endtask

  vec_t vecs[13];

  initial begin
    checks   = 0;
    failures = 0;
    rstn_i   = 1'b0;
    bus.core_be_i = 4'hF;
    bus.dbg_be_i  = 4'h3;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = v(1,0,32'h8000_0010,0, 0,0,0,0, 32'h0,
                 2'b10, mb(1,0,32'h10,0,4'hF), rs(0,0,0), rs(0,0,0));
    vecs[1]  = v(0,0,0,0, 1,1,32'h8000_0004,32'h1234_5678, 32'hDEAD_BEEF,
                 2'b01, mb(1,1,32'h4,32'h1234_5678,4'h3), rs(1,0,32'hDEAD_BEEF), rs(0,0,0));
    vecs[2]  = v(0,0,0,0, 1,0,32'h8000_0004,0, 32'hAAAA_5555,
                 2'b01, mb(1,0,32'h4,0,4'h3), rs(0,0,0), rs(1,0,0));
    vecs[3]  = v(1,1,32'h8000_FFFC,32'hCAFE_F00D, 0,0,0,0, 32'h1234_5678,
                 2'b10, mb(1,1,32'hFFFC,32'hCAFE_F00D,4'hF), rs(0,0,0), rs(1,0,32'h1234_5678));
    vecs[4]  = v(0,0,0,0, 1,0,32'h0000_1000,0, 32'h5555_0000,
                 2'b01, mb(0,0,0,0,0), rs(1,0,0), rs(0,0,0));
    vecs[5]  = v(0,0,0,0, 1,0,32'h8001_0000,0, 32'h0000_7777,
                 2'b01, mb(0,0,0,0,0), rs(0,0,0), rs(1,1,0));
    vecs[6]  = v(1,0,32'h7FFF_FFFC,0, 0,0,0,0, 32'h0000_0001,
                 2'b10, mb(0,0,0,0,0), rs(0,0,0), rs(1,1,0));
    vecs[7]  = v(0,0,0,0, 0,0,0,0, 32'h0000_0099,
                 2'b00, mb(0,0,0,0,0), rs(1,1,0), rs(0,0,0));
    vecs[8]  = v(0,0,0,0, 0,0,0,0, 32'h0,
                 2'b00, mb(0,0,0,0,0), rs(0,0,0), rs(0,0,0));
    vecs[9]  = v(0,0,0,0, 1,0,32'h8000_0008,0, 32'h0,
                 2'b01, mb(1,0,32'h8,0,4'h3), rs(0,0,0), rs(0,0,0));
    vecs[10] = v(1,0,32'h8000_0020,0, 0,0,0,0, 32'h1111_2222,
                 2'b10, mb(1,0,32'h20,0,4'hF), rs(0,0,0), rs(1,0,32'h1111_2222));
    vecs[11] = v(0,0,0,0, 0,0,0,0, 32'h3333_4444,
                 2'b00, mb(0,0,0,0,0), rs(1,0,32'h3333_4444), rs(0,0,0));
    vecs[12] = v(0,0,0,0, 0,0,0,0, 32'hFFFF_FFFF,
                 2'b00, mb(0,0,0,0,0), rs(0,0,0), rs(0,0,0));

    // Reset state: outputs idle, grant still combinational while in reset.
    repeat (2) @(negedge clk_i);
    chk("reset_idle", {bus.core_gnt_o, bus.dbg_gnt_o, mem_bus(), core_resp(), dbg_resp()}, '0);
    drive(1, 0, 32'h8000_0010, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_comb_gnt", {bus.core_gnt_o, bus.dbg_gnt_o, bus.mem_req_o}, 3'b101);
    @(negedge clk_i);
    chk("reset_no_rvalid", {core_resp(), dbg_resp()}, '0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn_i = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i);
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd, vecs[i].mrd);
      #2;
      chk($sformatf("vec%0d_gnt", i), {bus.core_gnt_o, bus.dbg_gnt_o}, vecs[i].gnt);
      chk($sformatf("vec%0d_mem", i), mem_bus(), vecs[i].mbus);
      chk($sformatf("vec%0d_core_resp", i), core_resp(), vecs[i].cresp);
      chk($sformatf("vec%0d_dbg_resp", i), dbg_resp(), vecs[i].dresp);
    end

    do_reset();
`ifdef DMEM_ARB_RR_EN
    arb_step(1, 1, 2'b01, "rr_first_dbg");
    arb_step(1, 1, 2'b10, "rr_core");
    arb_step(1, 1, 2'b01, "rr_dbg");
    arb_step(1, 1, 2'b10, "rr_core2");
    arb_step(0, 1, 2'b01, "rr_dbg_alone");
    arb_step(1, 1, 2'b10, "rr_after_dbg");
`else
    for (int i = 0; i < 3; i++) arb_step(1, 1, 2'b10, $sformatf("fix_a%0d", i));
    // Debug drops out: its wait count (3) must hold, not clear.
    for (int i = 0; i < 2; i++) arb_step(1, 0, 2'b10, $sformatf("fix_hold%0d", i));
    for (int i = 0; i < 5; i++) arb_step(1, 1, 2'b10, $sformatf("fix_b%0d", i));
    arb_step(1, 1, 2'b01, "fix_forced_dbg");
    for (int i = 0; i < 8; i++) begin
      arb_step(1, 1, 2'b10, $sformatf("fix_c%0d", i));
      if (i == 0) chk("fix_forced_dbg_resp", dbg_resp(), rs(1, 0, 32'h0BAD_F00D));
    end
    arb_step(1, 1, 2'b01, "fix_forced_dbg2");
    arb_step(1, 1, 2'b10, "fix_core_again");
`endif

    // Reset while a core read response is pending: the response must vanish.
    do_reset();
    @(negedge clk_i);
    drive(1, 0, 32'h8000_0010, 0, 0, 0, 0, 0, 32'h5A5A_5A5A);
    @(posedge clk_i);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_5A5A);
    rstn_i = 1'b0;
    #1;
    chk("rst_pending_in_reset", core_resp(), '0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk($sformatf("rst_pending_after%0d", i),
          {bus.core_gnt_o, bus.dbg_gnt_o, mem_bus(), core_resp(), dbg_resp()}, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the core's single data-memory port between the core load/store unit and the debug/host read-write port (`addr_i`/`data_o` path). It sits between `core_model` and the data memory. It grants at most one request per cycle and routes the one-cycle-latency read response back to the requester that issued it. Accesses outside the memory window complete locally with an error flag.

## Interface
- `XLEN`, `riscv_pkg::XLEN` (32): address/data width
- `MEM_BASE`, 32'h8000_0000: first byte address of memory window
- `MEM_BYTES`, 32'h0001_0000: window size in bytes (power of two)
- `MAX_WAIT`, 8: cycles a pending debug request may lose before forced grant (fixed-priority mode)

Ports:
- `clk_i` in 1: clock, rising edge
- `rstn_i` in 1: asynchronous active-low reset
- `core_req_i` / `dbg_req_i` in 1: request valid, held until granted
- `core_we_i` / `dbg_we_i` in 1: 1 = write
- `core_addr_i` / `dbg_addr_i` in XLEN: byte address, word aligned
- `core_wdata_i` / `dbg_wdata_i` in XLEN: write data
- `core_be_i` / `dbg_be_i` in 4: byte enables
- `core_gnt_o` / `dbg_gnt_o` out 1: request accepted this cycle
- `core_rvalid_o` / `dbg_rvalid_o` out 1: response valid (reads and writes)
- `core_rdata_o` / `dbg_rdata_o` out XLEN: read data, 0 for writes/errors
- `core_err_o` / `dbg_err_o` out 1: out-of-window access, qualified by rvalid
- `mem_req_o` out 1; `mem_we_o` out 1; `mem_addr_o` out XLEN (offset from MEM_BASE); `mem_wdata_o` out XLEN; `mem_be_o` out 4
- `mem_rdata_i` in XLEN: valid the cycle after `mem_req_o` with `mem_we_o`=0

## Operation
- Grant logic is combinational from current requests and state; at most one of `core_gnt_o`/`dbg_gnt_o` high.
- Only one requester: granted immediately.
- Both requesting, fixed-priority mode: core wins unless `wait_cnt == MAX_WAIT`, then debug wins.
- `wait_cnt` (width clog2(MAX_WAIT+1)): +1 each cycle `dbg_req_i` high and not granted, saturates at MAX_WAIT; clears to 0 on debug grant; holds when `dbg_req_i` low.
- In-window (`MEM_BASE <= addr < MEM_BASE+MEM_BYTES`) grant: drive `mem_req_o`=1 with granted requester's fields, `mem_addr_o = addr - MEM_BASE`.
- Out-of-window grant: `mem_req_o`=0; response next cycle with err=1, rdata=0.
- Response registers: `owner` (NONE/CORE/DBG), `err_q`, `rd_q` captured at grant edge. Next cycle, owner's rvalid=1; rdata = `mem_rdata_i` if read and not err, else 0. Non-owner outputs rvalid=0, rdata=0, err=0.
- No request: owner←NONE.
- Back-to-back grants allowed every cycle; no stall on response side (requesters always accept rvalid).

## Timing
- Reset (async assert, sync-to-clock deassert by parent): owner=NONE, wait_cnt=0, last_winner=CORE; all rvalid/err/rdata=0; gnt and mem_* follow requests combinationally (mem_* all 0 while no request).
- Grant latency 0 cycles from req; response latency exactly 1 cycle after grant.
- Reset asserted with response pending: response dropped, no rvalid after release.
- Request deasserted before grant: no state change, wait_cnt holds.
- Simultaneous grant and response for different requesters in same cycle: both legal, independent.
- Address exactly MEM_BASE+MEM_BYTES-4: in window; MEM_BASE+MEM_BYTES: error.
- Address subtraction modulo 2^XLEN; addresses below MEM_BASE are errors.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin on conflict; `last_winner` register updated on every grant, conflict grants the requester that is not `last_winner`; `wait_cnt` held at 0, MAX_WAIT unused.
- Undefined: fixed core priority with MAX_WAIT starvation guard as above; `last_winner` absent.

## Test plan
- Core read only: core_req, addr=0x8000_0010, mem returns 0xDEAD_BEEF -> core_gnt same cycle, mem_addr_o=0x10, next cycle core_rvalid=1, core_rdata=0xDEAD_BEEF, dbg_rvalid=0.
- Debug write 0x1234_5678 to 0x8000_0004, be=4'hF, then debug read same address -> mem_we_o=1 with mem_addr_o=0x4; read returns 0x1234_5678 on dbg_rdata_o; write response rdata=0.
- Fixed mode, both requesting continuously, MAX_WAIT=8 -> core granted 8 cycles, debug granted 9th, wait_cnt returns to 0, pattern repeats.
- With DMEM_ARB_RR_EN, both requesting continuously -> grants alternate core, dbg, core, dbg starting with dbg after reset.
- Debug read at 0x0000_1000 and at 0x8001_0000 -> mem_req_o=0, next cycle dbg_rvalid=1, dbg_err=1, dbg_rdata=0.
- Core read granted, rstn_i low before next edge -> no core_rvalid after reset release; all outputs at reset values.
